// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: PC generation, combinational ROM access, a
// DEPTH-entry fetch queue and a registered IF/ID output with branch flush.
module if_fetch_queue #(
   parameter int unsigned            ADDR_W   = 32,
   parameter int unsigned            INST_W   = 32,
   parameter int unsigned            DEPTH    = 4,
   parameter logic [ADDR_W-1:0]      RESET_PC = '0,
   parameter int unsigned            PC_STEP  = 4,
   localparam int unsigned           CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [INST_W-1:0] rom_data_i,
   output logic [ADDR_W-1:0] rom_addr_o,
   output logic              rom_ce_o,
   input  logic              stall_i,
   input  logic              branch_flag_i,
   input  logic [ADDR_W-1:0] branch_target_i,
   output logic [ADDR_W-1:0] id_pc_o,
   output logic [INST_W-1:0] id_inst_o,
   output logic              id_valid_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   logic [ADDR_W-1:0] pc_q, pc_d;
   entry_t            mem_q [DEPTH];
   entry_t            mem_d [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] id_pc_q, id_pc_d;
   logic [INST_W-1:0] id_inst_q, id_inst_d;
   logic              id_valid_q, id_valid_d;

   logic              fetch_c;
   logic              push_c;
   logic              pop_c;
   logic              full_c;

   // ROM is addressed by the live PC; fetch is suppressed only when full and stalled
   always_comb begin
      full_c     = (count_q == CNT_W'(DEPTH));
      rom_addr_o = pc_q;
      rom_ce_o   = !rst && (!full_c || !stall_i);
      fetch_c    = rom_ce_o && !branch_flag_i;
   end

   // Next-state: branch flush, fetch/PC advance, queue push/pop, IF/ID load
   always_comb begin
      pc_d       = pc_q;
      mem_d      = mem_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      id_pc_d    = id_pc_q;
      id_inst_d  = id_inst_q;
      id_valid_d = id_valid_q;
      push_c     = 1'b0;
      pop_c      = 1'b0;

      if (branch_flag_i) begin
         pc_d       = branch_target_i;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
         id_pc_d    = '0;
         id_inst_d  = '0;
         id_valid_d = 1'b0;
      end else begin
         if (fetch_c) begin
            pc_d = pc_q + ADDR_W'(PC_STEP);
         end

         if (!stall_i) begin
            if (count_q != '0) begin
               // Oldest buffered word goes to ID; current fetch joins the tail
               id_pc_d    = mem_q[rd_ptr_q].pc;
               id_inst_d  = mem_q[rd_ptr_q].inst;
               id_valid_d = 1'b1;
               pop_c      = 1'b1;
               push_c     = fetch_c;
            end else if (fetch_c) begin
               // Empty queue: bypass straight into the IF/ID register
               id_pc_d    = pc_q;
               id_inst_d  = rom_data_i;
               id_valid_d = 1'b1;
            end else begin
               id_pc_d    = '0;
               id_inst_d  = '0;
               id_valid_d = 1'b0;
            end
         end else begin
            push_c = fetch_c;
         end

         if (push_c) begin
            mem_d[wr_ptr_q].pc   = pc_q;
            mem_d[wr_ptr_q].inst = rom_data_i;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end

         if (push_c && !pop_c) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop_c && !push_c) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // State registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         id_pc_q    <= '0;
         id_inst_q  <= '0;
         id_valid_q <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         pc_q       <= pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         id_pc_q    <= id_pc_d;
         id_inst_q  <= id_inst_d;
         id_valid_q <= id_valid_d;
         mem_q      <= mem_d;
      end
   end

   // Registered outputs to decode
   always_comb begin
      id_pc_o    = id_pc_q;
      id_inst_o  = id_inst_q;
      id_valid_o = id_valid_q;
      count_o    = count_q;
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue against a queue-based reference model.
module tb_if_fetch_queue;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        branch;
   logic [31:0] target;
   logic [31:0] rom_addr, rom_data, id_pc, id_inst;
   logic        rom_ce, id_valid;
   logic [2:0]  count;

   logic [31:0] w_rom_addr, w_rom_data, w_id_pc, w_id_inst;
   logic        w_rom_ce, w_id_valid;
   logic [2:0]  w_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [31:0] m_pc, m_id_pc, m_id_inst;
   logic        m_id_valid;
   logic [31:0] m_q[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
   endfunction

   assign rom_data   = rom_f(rom_addr);
   assign w_rom_data = rom_f(w_rom_addr);

   if_fetch_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .rom_data_i(rom_data), .rom_addr_o(rom_addr),
      .rom_ce_o(rom_ce), .stall_i(stall), .branch_flag_i(branch),
      .branch_target_i(target), .id_pc_o(id_pc), .id_inst_o(id_inst),
      .id_valid_o(id_valid), .count_o(count)
   );

   if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
      .clk(clk), .rst(rst), .rom_data_i(w_rom_data), .rom_addr_o(w_rom_addr),
      .rom_ce_o(w_rom_ce), .stall_i(1'b0), .branch_flag_i(1'b0),
      .branch_target_i(32'h0), .id_pc_o(w_id_pc), .id_inst_o(w_id_inst),
      .id_valid_o(w_id_valid), .count_o(w_count)
   );

   task automatic model_reset();
      m_pc       = 32'h0;
      m_q.delete();
      m_id_pc    = 32'h0;
      m_id_inst  = 32'h0;
      m_id_valid = 1'b0;
   endtask

   // Advance the model by one cycle using the current inputs, then clock the DUT
   task automatic step();
      bit ce;
      ce = (m_q.size() < int'(DEPTH)) || !stall;
      if (branch) begin
         m_pc = target;
         m_q.delete();
         m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
      end else begin
         if (!stall) begin
            if (m_q.size() > 0) begin
               m_id_pc    = m_q.pop_front();
               m_id_inst  = rom_f(m_id_pc);
               m_id_valid = 1'b1;
               if (ce) m_q.push_back(m_pc);
            end else if (ce) begin
               m_id_pc = m_pc; m_id_inst = rom_f(m_pc); m_id_valid = 1'b1;
            end else begin
               m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
            end
         end else if (ce) begin
            m_q.push_back(m_pc);
         end
         if (ce) m_pc = m_pc + 32'd4;
      end
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; branch = 1'b0; target = 32'h0;
      #1;
      checks++; if (rom_ce !== 1'b0) begin errors++; $display("FAIL reset_rom_ce: got %b expected 0", rom_ce); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
         errors++; $display("FAIL reset_id: got valid=%b pc=%h inst=%h expected 0/0/0", id_valid, id_pc, id_inst); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      checks++; if (rom_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr: got %h expected 0", rom_addr); end
      for (int i = 0; i < 8; i++) begin
         step();
         checks++; if (rom_addr !== 32'(4 * (i + 1))) begin
            errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", i, rom_addr, 32'(4 * (i + 1))); end
         checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 * i) || id_inst !== rom_f(32'(4 * i))) begin
            errors++; $display("FAIL stream_id[%0d]: got v=%b pc=%h inst=%h expected pc=%h", i, id_valid, id_pc, id_inst, 32'(4 * i)); end
         checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 0", i, count); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_w [4];
      exp_w = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
      do_reset(2);
      for (int k = 0; k < 4; k++) begin
         checks++; if (w_rom_addr !== exp_w[k]) begin
            errors++; $display("FAIL wrap_addr[%0d]: got %h expected %h", k, w_rom_addr, exp_w[k]); end
         step();
      end
   endtask

   task automatic test_stall_fill();
      logic [2:0] exp_cnt [6];
      exp_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
      do_reset(2);
      step();
      checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1) begin
         errors++; $display("FAIL fill_start: got pc=%h v=%b expected 0/1", id_pc, id_valid); end
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (count !== exp_cnt[i]) begin
            errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, exp_cnt[i]); end
         checks++; if (id_pc !== 32'h0) begin errors++; $display("FAIL fill_hold[%0d]: got %h expected 0", i, id_pc); end
         if (i >= 3) begin
            checks++; if (rom_ce !== 1'b0 || rom_addr !== 32'h14) begin
               errors++; $display("FAIL fill_full[%0d]: got ce=%b addr=%h expected 0/14", i, rom_ce, rom_addr); end
         end
      end
      stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++; if (id_valid !== 1'b1 || id_pc !== 32'(4 + 4 * i) || id_inst !== rom_f(32'(4 + 4 * i))) begin
            errors++; $display("FAIL drain_id[%0d]: got v=%b pc=%h expected pc=%h", i, id_valid, id_pc, 32'(4 + 4 * i)); end
      end
   endtask

   task automatic test_full_stream();
      logic [31:0] prev;
      prev = id_pc;
      stall = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count[%0d]: got %0d expected 4", i, count); end
         checks++; if (id_pc !== prev + 32'd4 || id_valid !== 1'b1) begin
            errors++; $display("FAIL full_seq[%0d]: got %h expected %h", i, id_pc, prev + 32'd4); end
         prev = prev + 32'd4;
      end
   endtask

   task automatic test_branch_full();
      stall = 1'b1;
      step(); step();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL br_prefull: got %0d expected 4", count); end
      branch = 1'b1; target = 32'h100;
      step();
      branch = 1'b0;
      checks++; if (count !== 3'd0 || id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
         errors++; $display("FAIL br_flush: got cnt=%0d v=%b pc=%h inst=%h expected 0/0/0/0", count, id_valid, id_pc, id_inst); end
      checks++; if (rom_addr !== 32'h100) begin errors++; $display("FAIL br_addr: got %h expected 100", rom_addr); end
      stall = 1'b0;
      step();
      checks++; if (id_pc !== 32'h100 || id_valid !== 1'b1 || id_inst !== rom_f(32'h100)) begin
         errors++; $display("FAIL br_first: got pc=%h v=%b expected 100/1", id_pc, id_valid); end
      step();
      checks++; if (id_pc !== 32'h104) begin errors++; $display("FAIL br_second: got %h expected 104", id_pc); end
   endtask

   task automatic test_async_reset();
      stall = 1'b1;
      step(); step(); step();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL ar_precount: got %0d expected 3", count); end
      #2;
      rst = 1'b1;
      stall = 1'b0;
      #1;
      checks++; if (count !== 3'd0 || rom_ce !== 1'b0 || rom_addr !== 32'h0) begin
         errors++; $display("FAIL ar_state: got cnt=%0d ce=%b addr=%h expected 0/0/0", count, rom_ce, rom_addr); end
      checks++; if (id_valid !== 1'b0 || id_inst !== 32'h0 || id_pc !== 32'h0) begin
         errors++; $display("FAIL ar_id: got v=%b pc=%h inst=%h expected 0/0/0", id_valid, id_pc, id_inst); end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      step();
      checks++; if (id_pc !== 32'h0 || id_valid !== 1'b1 || rom_addr !== 32'h4) begin
         errors++; $display("FAIL ar_restart: got pc=%h v=%b addr=%h expected 0/1/4", id_pc, id_valid, rom_addr); end
   endtask

   task automatic test_random();
      bit ce_exp;
      for (int i = 0; i < 400; i++) begin
         stall  = ($urandom_range(0, 99) < 45);
         branch = ($urandom_range(0, 99) < 6);
         target = $urandom() & 32'hFFFF_FFFC;
         #1;
         ce_exp = (m_q.size() < int'(DEPTH)) || !stall;
         checks++; if (rom_ce !== ce_exp || rom_addr !== m_pc) begin
            errors++; $display("FAIL rnd_rom[%0d]: got ce=%b addr=%h expected %b/%h", i, rom_ce, rom_addr, ce_exp, m_pc); end
         step();
         checks++; if (id_valid !== m_id_valid || id_pc !== m_id_pc || id_inst !== m_id_inst) begin
            errors++; $display("FAIL rnd_id[%0d]: got v=%b pc=%h inst=%h expected %b/%h/%h",
                               i, id_valid, id_pc, id_inst, m_id_valid, m_id_pc, m_id_inst); end
         checks++; if (count !== 3'(m_q.size())) begin
            errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, count, m_q.size()); end
      end
      branch = 1'b0;
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_stall_fill();
      test_full_stream();
      test_branch_full();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
